axi_lite_sram_resp: RTL and testbench



---
 rtl/axi_lite_sram_resp_pkg.sv | 27 ++
 rtl/axi_lite_sram_resp_lfsr8.sv | 25 ++
 rtl/axi_lite_sram_resp.sv | 181 ++++++++++++++++++
 tb/tb_axi_lite_sram_resp.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_sram_resp_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// transfer-size codes, FSM state encodings and the response-code helper.
package axi_lite_sram_resp_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        SIZE_B = 3'd0,
        SIZE_H = 3'd1,
        SIZE_W = 3'd2
    } axi_size_e;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_WAIT = 3'd1;
    localparam logic [2:0] ST_RD_RESP = 3'd2;
    localparam logic [2:0] ST_WR_WAIT = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;

    // Wide enough for LATENCY (max 15) plus up to 3 random extra cycles.
    localparam int CNT_W = 5;

    function automatic logic [1:0] resp_code(input logic err);
        return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_sram_resp_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) seeded 8'hA5; supplies the 0..3 cycle
// extra response delay used when SRAM_RAND_DELAY_EN is defined.
module axi_lite_sram_resp_lfsr8 (
    input  logic       clock,
    input  logic       reset,
    output logic [1:0] delay_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       feedback;

    assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_d   = {lfsr_q[6:0], feedback};
    assign delay_o  = lfsr_q[1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/axi_lite_sram_resp.sv
// AXI4-Lite responder modelling a word-organised SRAM, one transaction at a time.
// Define SRAM_RAND_DELAY_EN to add 0..3 LFSR-driven cycles to every response.
module axi_lite_sram_resp
    import axi_lite_sram_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr_i,
    input  logic [2:0]  arsize_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    input  logic [31:0] awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;
    logic [1:0]       bresp_q;
    logic             rd_load;
    logic             wr_apply;

    logic [31:0]      mem [DEPTH_WORDS];

    // Offsets wrap below BASE_ADDR, so a single unsigned compare covers both bounds.
    logic [31:0]      ar_off, aw_off;
    logic             ar_in_range, aw_in_range;
    logic             aw_w_valid;
    logic [CNT_W-1:0] lat_total;

    assign ar_off      = araddr_i - BASE_ADDR;
    assign aw_off      = awaddr_i - BASE_ADDR;
    assign ar_in_range = ar_off < SPAN_BYTES;
    assign aw_in_range = aw_off < SPAN_BYTES;
    assign aw_w_valid  = awvalid_i & wvalid_i;

`ifdef SRAM_RAND_DELAY_EN
    logic [1:0] rand_delay;

    axi_lite_sram_resp_lfsr8 u_lfsr8 (
        .clock   (clock),
        .reset   (reset),
        .delay_o (rand_delay)
    );

    assign lat_total = CNT_W'(LATENCY) + CNT_W'(rand_delay);
`else
    assign lat_total = CNT_W'(LATENCY);
`endif

    assign arready_o = ~reset & (state_q == ST_IDLE);
    assign awready_o = ~reset & (state_q == ST_IDLE) & aw_w_valid & ~arvalid_i;
    assign wready_o  = awready_o;
    assign rvalid_o  = (state_q == ST_RD_RESP);
    assign bvalid_o  = (state_q == ST_WR_RESP);
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign bresp_o   = bresp_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rd_load  = 1'b0;
        wr_apply = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arvalid_i) begin
                    idx_d   = ar_off[IDX_W+1:2];
                    err_d   = ~ar_in_range | (arsize_i > SIZE_W);
                    cnt_d   = lat_total;
                    rd_load = (lat_total == '0);
                    state_d = rd_load ? ST_RD_RESP : ST_RD_WAIT;
                end else if (aw_w_valid) begin
                    idx_d    = aw_off[IDX_W+1:2];
                    err_d    = ~aw_in_range;
                    wdata_d  = wdata_i;
                    wstrb_d  = wstrb_i;
                    cnt_d    = lat_total;
                    wr_apply = (lat_total == '0);
                    state_d  = wr_apply ? ST_WR_RESP : ST_WR_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    rd_load = 1'b1;
                    state_d = ST_RD_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RD_RESP: begin
                if (rready_i) state_d = ST_IDLE;
            end
            ST_WR_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d    = '0;
                    wr_apply = 1'b1;
                    state_d  = ST_WR_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_RESP: begin
                if (bready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data is sampled on entry to RD_RESP so it reflects every completed write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            rresp_q <= AXI_RESP_OKAY;
            bresp_q <= AXI_RESP_OKAY;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            if (rd_load) begin
                rdata_q <= err_d ? 32'h0 : mem[idx_d];
                rresp_q <= resp_code(err_d);
            end
            if (wr_apply) begin
                bresp_q <= resp_code(err_d);
            end
        end
    end

    // NOTE: the array has no reset branch; clearing thousands of words would
    // stop it mapping onto a RAM macro. Reset only blocks an un-applied write.
    always_ff @(posedge clock) begin
        if (!reset && wr_apply && !err_d) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_d[b]) mem[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram_resp.sv
// Directed self-checking bench for axi_lite_sram_resp (default build): one
// LATENCY=1 instance for the main tests, one LATENCY=4 instance for mid-read reset.
module tb_axi_lite_sram_resp;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] araddr = '0;
    logic [2:0]  arsize = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    logic [31:0] araddr4 = '0;
    logic        arvalid4 = 1'b0;
    logic        arready4;
    logic [31:0] rdata4;
    logic [1:0]  rresp4;
    logic        rvalid4;
    logic        rready4 = 1'b0;
    logic        awready4, wready4, bvalid4;
    logic [1:0]  bresp4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    axi_lite_sram_resp #(.LATENCY(1)) u_dut (
        .clock(clock), .reset(reset),
        .araddr_i(araddr), .arsize_i(arsize), .arvalid_i(arvalid), .arready_o(arready),
        .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
        .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
        .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready)
    );

    axi_lite_sram_resp #(.LATENCY(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .araddr_i(araddr4), .arsize_i(3'd2), .arvalid_i(arvalid4), .arready_o(arready4),
        .rdata_o(rdata4), .rresp_o(rresp4), .rvalid_o(rvalid4), .rready_i(rready4),
        .awaddr_i(32'h0), .awvalid_i(1'b0), .awready_o(awready4),
        .wdata_i(32'h0), .wstrb_i(4'h0), .wvalid_i(1'b0), .wready_o(wready4),
        .bresp_o(bresp4), .bvalid_o(bvalid4), .bready_i(1'b0)
    );

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input string name);
        int n;
        @(negedge clock);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL %s aw/w ready: got %b/%b want 1/1", name, awready, wready);
        end
        @(posedge clock);
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 1;
        while (bvalid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL %s bvalid latency: got %0d want 2", name, n);
        end
        checks++;
        if (bresp !== exp_resp) begin
            errors++;
            $display("FAIL %s bresp: got %b want %b", name, bresp, exp_resp);
        end
        @(negedge clock);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s bvalid after B handshake: got %b want 0", name, bvalid);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input string name);
        int n;
        @(negedge clock);
        araddr = addr; arsize = size; arvalid = 1'b1; rready = 1'b1;
        #1;
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL %s arready: got %b want 1", name, arready);
        end
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        n = 1;
        while (rvalid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL %s rvalid latency: got %0d want 2", name, n);
        end
        checks++;
        if (rdata !== exp_data || rresp !== exp_resp) begin
            errors++;
            $display("FAIL %s rdata/rresp: got %h/%b want %h/%b", name, rdata, rresp, exp_data, exp_resp);
        end
        @(negedge clock);
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s rvalid after R handshake: got %b want 0", name, rvalid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (arready !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL reset ready: got ar=%b aw=%b w=%b want 0/0/0", arready, awready, wready);
        end
        @(negedge clock);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; reset = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0 || rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL reset outputs: got rv=%b bv=%b rdata=%h rresp=%b bresp=%b want all 0",
                     rvalid, bvalid, rdata, rresp, bresp);
        end
        checks++;
        if (arready !== 1'b1 || rvalid4 !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: got arready=%b rvalid4=%b want 1/0", arready, rvalid4);
        end
    endtask

    task automatic test_word_write_read();
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, "word_write");
        do_read (32'h8000_0010, 3'd2, 32'hDEAD_BEEF, 2'b00, "word_read");
    endtask

    task automatic test_byte_half();
        do_write(32'h8000_0010, 32'h00AA_0000, 4'b0100, 2'b00, "byte_write");
        do_write(32'h8000_0012, 32'h0000_1234, 4'b0011, 2'b00, "half_write");
        do_read (32'h8000_0010, 3'd2, 32'hDEAA_1234, 2'b00, "byte_half_read");
        do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 2'b00, "strb0_write");
        do_read (32'h8000_0010, 3'd0, 32'hDEAA_1234, 2'b00, "strb0_read");
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clock);
        araddr = 32'h8000_0010; arsize = 3'd2; arvalid = 1'b1; rready = 1'b1;
        awaddr = 32'h8000_0020; wdata = 32'h1122_3344; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b1;
        #1;
        checks++;
        if (arready !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL simul priority: got ar=%b aw=%b w=%b want 1/0/0", arready, awready, wready);
        end
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        n = 1;
        while (rvalid !== 1'b1 && n < 50) begin
            checks++;
            if (awready !== 1'b0) begin
                errors++;
                $display("FAIL simul aw held off: got awready=%b want 0", awready);
            end
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 2 || rdata !== 32'hDEAA_1234) begin
            errors++;
            $display("FAIL simul read: got lat=%0d rdata=%h want 2/deaa1234", n, rdata);
        end
        @(negedge clock);
        rready = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL simul write accept: got rv=%b aw=%b w=%b want 0/1/1", rvalid, awready, wready);
        end
        @(posedge clock);
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 1;
        while (bvalid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 2 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL simul write resp: got lat=%0d bresp=%b want 2/00", n, bresp);
        end
        @(negedge clock);
        bready = 1'b0;
        do_read(32'h8000_0020, 3'd2, 32'h1122_3344, 2'b00, "simul_readback");
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clock);
        araddr = 32'h8000_0010; arsize = 3'd2; arvalid = 1'b1; rready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        n = 1;
        while (rvalid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL bp latency: got %0d want 2", n);
        end
        arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rvalid !== 1'b1 || rdata !== 32'hDEAA_1234 || rresp !== 2'b00 || arready !== 1'b0) begin
                errors++;
                $display("FAIL bp hold cycle %0d: got rv=%b rdata=%h rresp=%b ar=%b want 1/deaa1234/00/0",
                         i, rvalid, rdata, rresp, arready);
            end
            @(negedge clock);
        end
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clock);
        rready = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL bp release: got rv=%b ar=%b want 0/1", rvalid, arready);
        end
    endtask

    task automatic test_errors();
        do_read (32'h7FFF_FFFC, 3'd2, 32'h0, 2'b10, "err_below_base");
        do_read (32'h8000_0010, 3'd3, 32'h0, 2'b10, "err_arsize3");
        do_read (32'h8000_4000, 3'd2, 32'h0, 2'b10, "err_above_top");
        do_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 2'b00, "word0_write");
        do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 2'b10, "err_write");
        do_read (32'h8000_0000, 3'd2, 32'h0BAD_F00D, 2'b00, "err_write_no_alias");
        do_write(32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 2'b00, "top_word_write");
        do_read (32'h8000_3FFC, 3'd2, 32'hCAFE_F00D, 2'b00, "top_word_read");
    endtask

    task automatic test_reset_mid_read();
        int n;
        @(negedge clock);
        araddr4 = 32'h8000_0010; arvalid4 = 1'b1; rready4 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        arvalid4 = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (arready !== 1'b0 || arready4 !== 1'b0) begin
            errors++;
            $display("FAIL mid reset arready: got %b/%b want 0/0", arready, arready4);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (rvalid4 !== 1'b0) begin
                errors++;
                $display("FAIL dropped read cycle %0d: got rvalid4=%b want 0", i, rvalid4);
            end
            @(negedge clock);
        end
        araddr4 = 32'h8000_0010; arvalid4 = 1'b1;
        #1;
        checks++;
        if (arready4 !== 1'b1) begin
            errors++;
            $display("FAIL post reset arready4: got %b want 1", arready4);
        end
        @(posedge clock);
        @(negedge clock);
        arvalid4 = 1'b0;
        n = 1;
        while (rvalid4 !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 5 || rresp4 !== 2'b00) begin
            errors++;
            $display("FAIL post reset read: got lat=%0d rresp=%b want 5/00", n, rresp4);
        end
        @(negedge clock);
        rready4 = 1'b0;
        checks++;
        if (rvalid4 !== 1'b0) begin
            errors++;
            $display("FAIL post reset R handshake: got rvalid4=%b want 0", rvalid4);
        end
    endtask

    initial begin
        test_reset();
        test_word_write_read();
        test_byte_half();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_reset_mid_read();
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
